// File: rtl/rx_bit_deserializer.sv
// rx_bit_deserializer: full-speed USB receive path - bit recovery, NRZI decode, unstuffing and byte assembly
module rx_bit_deserializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    input  logic       rcv_enable,
    output logic [7:0] Packet_Data,
    output logic       byte_complete,
    output logic       eop,
    output logic       stuff_error,
    output logic       align_error,
    output logic       receiving
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RECEIVE  = 2'd1;
    localparam logic [1:0] EOP_WAIT = 2'd2;

    logic [1:0] state, phase;
    logic [2:0] ones, bit_cnt;
    logic [7:0] shift;
    logic       dp_d, dm_d, prev;
    logic       strobe, se0, k, bit_in, stuffed, decode, eop_hit;

    // The phase counter lags the line by one clk, so the line is sampled from the matching delayed copy
    assign strobe    = phase == 2'd2;
    assign se0       = !dp_d && !dm_d;
    assign k         = !dp_d && dm_d;
    assign bit_in    = dp_d == prev;
    assign stuffed   = ones == 3'd6;
    assign decode    = strobe && (state == IDLE ? k : !se0);
    assign eop_hit   = strobe && state == EOP_WAIT && se0;
    assign receiving = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            phase         <= 2'd0;
            dp_d          <= 1'b1;
            dm_d          <= 1'b0;
            prev          <= 1'b1;
            ones          <= 3'd0;
            bit_cnt       <= 3'd0;
            shift         <= 8'h00;
            Packet_Data   <= 8'h00;
            byte_complete <= 1'b0;
            eop           <= 1'b0;
            stuff_error   <= 1'b0;
            align_error   <= 1'b0;
        end else begin
            dp_d          <= d_plus_sync;
            dm_d          <= d_minus_sync;
            phase         <= (!rcv_enable || d_plus_sync != dp_d) ? 2'd0 : phase + 2'd1;
            byte_complete <= 1'b0;
            eop           <= 1'b0;
            stuff_error   <= 1'b0;
            align_error   <= 1'b0;
            if (!rcv_enable || eop_hit) begin
                state       <= IDLE;
                prev        <= 1'b1;
                ones        <= 3'd0;
                bit_cnt     <= 3'd0;
                shift       <= 8'h00;
                eop         <= rcv_enable;
                align_error <= rcv_enable && bit_cnt != 3'd0;
            end else if (decode) begin
                state       <= RECEIVE;
                prev        <= dp_d;
                ones        <= (stuffed || !bit_in) ? 3'd0 : ones + 3'd1;
                stuff_error <= stuffed && bit_in;
                if (!stuffed) begin
                    shift   <= {shift[6:0], bit_in};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        Packet_Data   <= {shift[6:0], bit_in};
                        byte_complete <= 1'b1;
                    end
                end
            end else if (strobe && state == RECEIVE && se0) begin
                state <= EOP_WAIT;
            end
        end
    end
endmodule

// File: tb/tb_rx_bit_deserializer.sv
// tb_rx_bit_deserializer: directed checks of SYNC, PID, stuffing, alignment, jitter and aborts
module tb_rx_bit_deserializer;
    logic       clk = 1'b0;
    logic       rst, d_plus_sync, d_minus_sync, rcv_enable;
    logic [7:0] Packet_Data;
    logic       byte_complete, eop, stuff_error, align_error, receiving;
    int         n_assert = 0, n_fail = 0;
    int         bc_n = 0, eop_n = 0, se_n = 0, ae_n = 0, both_n = 0;
    logic [7:0] last_pd = 8'h00;
    int         b0, e0, s0, a0, c0;
    logic       tx_dp;
    int         tx_ones;

    rx_bit_deserializer dut (
        .clk(clk),
        .rst(rst),
        .d_plus_sync(d_plus_sync),
        .d_minus_sync(d_minus_sync),
        .rcv_enable(rcv_enable),
        .Packet_Data(Packet_Data),
        .byte_complete(byte_complete),
        .eop(eop),
        .stuff_error(stuff_error),
        .align_error(align_error),
        .receiving(receiving)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (byte_complete) begin
            bc_n    <= bc_n + 1;
            last_pd <= Packet_Data;
        end
        if (eop) eop_n <= eop_n + 1;
        if (stuff_error) se_n <= se_n + 1;
        if (align_error) ae_n <= ae_n + 1;
        if (eop && align_error) both_n <= both_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b0 = bc_n;
        e0 = eop_n;
        s0 = se_n;
        a0 = ae_n;
        c0 = both_n;
    endtask

    task automatic line(input logic dp, input logic dm, input int n);
        d_plus_sync  = dp;
        d_minus_sync = dm;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // NRZI transmitter model: a 0 toggles the line, six 1s force a stuffed 0 when stf is set
    task automatic send_bit(input logic b, input logic stf, input int len);
        if (!b) tx_dp = !tx_dp;
        line(tx_dp, !tx_dp, len);
        tx_ones = b ? tx_ones + 1 : 0;
        if (stf && tx_ones == 6) begin
            tx_dp = !tx_dp;
            line(tx_dp, !tx_dp, 4);
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic stf);
        for (int i = 7; i >= 0; i--) send_bit(v[i], stf, 4);
    endtask

    task automatic send_eop();
        line(1'b0, 1'b0, 8);
        tx_dp   = 1'b1;
        tx_ones = 0;
        line(1'b1, 1'b0, 12);
    endtask

    initial begin
        rst          = 1'b1;
        rcv_enable   = 1'b0;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        tx_dp        = 1'b1;
        tx_ones      = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(Packet_Data), 32'h00);
        check("rst_byte_complete", 32'(byte_complete), 32'h0);
        check("rst_eop", 32'(eop), 32'h0);
        check("rst_stuff_error", 32'(stuff_error), 32'h0);
        check("rst_align_error", 32'(align_error), 32'h0);
        check("rst_receiving", 32'(receiving), 32'h0);
        rst = 1'b0;
        line(1'b0, 1'b1, 12);
        check("disabled_receiving", 32'(receiving), 32'h0);
        rcv_enable = 1'b1;
        line(1'b1, 1'b0, 12);
        check("disabled_bc", bc_n, 32'd0);

        snap();
        send_byte(8'h01, 1'b1);
        check("sync_data", 32'(Packet_Data), 32'h01);
        check("sync_receiving", 32'(receiving), 32'h1);
        send_byte(8'h69, 1'b1);
        check("pid_data", 32'(Packet_Data), 32'h69);
        send_eop();
        check("pid_bc", bc_n - b0, 32'd2);
        check("pid_eop", eop_n - e0, 32'd1);
        check("pid_align", ae_n - a0, 32'd0);
        check("pid_stuff", se_n - s0, 32'd0);
        check("pid_receiving", 32'(receiving), 32'h0);

        snap();
        send_byte(8'h01, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_eop();
        check("stuffed_bc", bc_n - b0, 32'd2);
        check("stuffed_data", 32'(last_pd), 32'hFE);
        check("stuffed_stuff", se_n - s0, 32'd0);
        check("stuffed_eop", eop_n - e0, 32'd1);

        snap();
        send_byte(8'h01, 1'b1);
        send_byte(8'hFE, 1'b0);
        send_bit(1'b0, 1'b0, 4);
        send_eop();
        check("stufferr_stuff", se_n - s0, 32'd1);
        check("stufferr_bc", bc_n - b0, 32'd2);
        check("stufferr_data", 32'(last_pd), 32'hFC);
        check("stufferr_align", ae_n - a0, 32'd0);

        snap();
        send_byte(8'h01, 1'b1);
        send_bit(1'b1, 1'b1, 4);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b1, 1'b1, 4);
        send_bit(1'b1, 1'b1, 4);
        send_bit(1'b0, 1'b1, 4);
        send_eop();
        check("align_eop", eop_n - e0, 32'd1);
        check("align_align", ae_n - a0, 32'd1);
        check("align_coincident", both_n - c0, 32'd1);
        check("align_data", 32'(Packet_Data), 32'h01);
        check("align_bc", bc_n - b0, 32'd1);

        snap();
        send_byte(8'h01, 1'b1);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b1, 1'b1, 4);
        send_bit(1'b1, 1'b1, 5);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b1, 1'b1, 3);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b1, 1'b1, 4);
        send_eop();
        check("jitter_bc", bc_n - b0, 32'd2);
        check("jitter_data", 32'(last_pd), 32'h69);
        check("jitter_eop", eop_n - e0, 32'd1);

        snap();
        send_byte(8'h01, 1'b1);
        send_bit(1'b1, 1'b1, 4);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b1, 1'b1, 4);
        rcv_enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_en_receiving", 32'(receiving), 32'h0);
        tx_dp   = 1'b1;
        tx_ones = 0;
        line(1'b1, 1'b0, 16);
        check("abort_en_bc", bc_n - b0, 32'd1);
        check("abort_en_eop", eop_n - e0, 32'd0);
        check("abort_en_align", ae_n - a0, 32'd0);
        rcv_enable = 1'b1;
        line(1'b1, 1'b0, 8);
        snap();
        send_byte(8'h01, 1'b1);
        check("abort_en_sync", 32'(Packet_Data), 32'h01);
        send_eop();
        check("abort_en_next_eop", eop_n - e0, 32'd1);
        check("abort_en_next_align", ae_n - a0, 32'd0);

        snap();
        send_byte(8'h01, 1'b1);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b1, 1'b1, 4);
        send_bit(1'b1, 1'b1, 4);
        rst = 1'b1;
        #1;
        check("abort_rst_receiving", 32'(receiving), 32'h0);
        check("abort_rst_data", 32'(Packet_Data), 32'h00);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        tx_dp   = 1'b1;
        tx_ones = 0;
        line(1'b1, 1'b0, 16);
        check("abort_rst_eop", eop_n - e0, 32'd0);
        check("abort_rst_align", ae_n - a0, 32'd0);
        snap();
        send_byte(8'h01, 1'b1);
        check("abort_rst_sync", 32'(Packet_Data), 32'h01);
        send_eop();
        check("abort_rst_next_bc", bc_n - b0, 32'd1);
        check("abort_rst_next_eop", eop_n - e0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
